// File: rtl/regfile_writeback.sv
// Register-file write-port front end: merges ALU results and buffered LSU loads onto
// one registered write port, and tracks registers still waiting on an outstanding load.
module regfile_writeback #(
  parameter int RegisterSize = 5,
  parameter int OperandSize  = 32,
  parameter int NumRegisters = 32,
  parameter int FifoDepth    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [RegisterSize-1:0]     alu_rd,
  input  logic [OperandSize-1:0]      alu_data,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [RegisterSize-1:0]     lsu_rd,
  input  logic [OperandSize-1:0]      lsu_data,
  input  logic                        load_issue,
  input  logic [RegisterSize-1:0]     load_issue_rd,
  input  logic [RegisterSize-1:0]     query_rs1,
  input  logic [RegisterSize-1:0]     query_rs2,
  output logic                        hazard_1,
  output logic                        hazard_2,
  output logic [RegisterSize-1:0]     addr_3,
  output logic                        write_enable_3,
  output logic [OperandSize-1:0]      write_data_3,
  output logic [$clog2(FifoDepth):0]  fifo_count
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth) + 1;

  logic [RegisterSize-1:0] fifo_rd_mem   [FifoDepth];
  logic [OperandSize-1:0]  fifo_data_mem [FifoDepth];

  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [NumRegisters-1:0] pending_q, pending_d;
  logic [RegisterSize-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [OperandSize-1:0]  wdata_q, wdata_d;

  logic                    full;
  logic                    empty;
  logic                    alu_win;
  logic                    pop;
  logic                    push;
  logic [RegisterSize-1:0] head_rd;
  logic [OperandSize-1:0]  head_data;

  // LSU handshake: a transfer happens on any cycle with lsu_valid && lsu_ready.
  // lsu_ready depends only on FIFO occupancy (pre-pop) and reset, never on lsu_valid;
  // the producer keeps lsu_rd/lsu_data stable while lsu_valid && !lsu_ready.
  assign full      = (count_q == CntW'(FifoDepth));
  assign empty     = (count_q == '0);
  assign lsu_ready = !rst && !full;

  assign head_rd   = fifo_rd_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];

  // Loads to x0 complete the handshake but are dropped instead of enqueued.
  assign alu_win = alu_valid && (alu_rd != '0);
  assign pop     = !alu_win && !empty;
  assign push    = lsu_valid && lsu_ready && (lsu_rd != '0);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;

    if (alu_win) begin
      we_d    = 1'b1;
      addr_d  = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      we_d    = 1'b1;
      addr_d  = head_rd;
      wdata_d = head_data;
    end

    if (pop) begin
      rd_ptr_d           = rd_ptr_q + PtrW'(1);
      pending_d[head_rd] = 1'b0;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    // Applied after the pop clear so a freshly issued load to the same rd stays pending.
    if (load_issue && (load_issue_rd != '0)) begin
      pending_d[load_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_q]   <= lsu_rd;
      fifo_data_mem[wr_ptr_q] <= lsu_data;
    end
  end

  // The write on the port this cycle is not yet in the register file, so it still counts.
  always_comb begin
    hazard_1 = (query_rs1 != '0) &&
               (pending_q[query_rs1] || (we_q && (addr_q == query_rs1)));
    hazard_2 = (query_rs2 != '0) &&
               (pending_q[query_rs2] || (we_q && (addr_q == query_rs2)));
  end

  assign addr_3         = addr_q;
  assign write_enable_3 = we_q;
  assign write_data_3   = wdata_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: queue-based reference model, expected-write
// scoreboard drained by an independent port monitor.
module tb_regfile_writeback;

  localparam int RS = 5;
  localparam int OS = 32;
  localparam int NR = 32;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;
  localparam int EW = RS + OS;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [RS-1:0] alu_rd;
  logic [OS-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [RS-1:0] lsu_rd;
  logic [OS-1:0] lsu_data;
  logic          load_issue;
  logic [RS-1:0] load_issue_rd;
  logic [RS-1:0] query_rs1;
  logic [RS-1:0] query_rs2;
  logic          hazard_1;
  logic          hazard_2;
  logic [RS-1:0] addr_3;
  logic          write_enable_3;
  logic [OS-1:0] write_data_3;
  logic [CW-1:0] fifo_count;

  // clock / reset
  always #5 clk = ~clk;

  regfile_writeback #(
    .RegisterSize(RS), .OperandSize(OS), .NumRegisters(NR), .FifoDepth(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .load_issue(load_issue), .load_issue_rd(load_issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .hazard_1(hazard_1), .hazard_2(hazard_2),
    .addr_3(addr_3), .write_enable_3(write_enable_3), .write_data_3(write_data_3),
    .fifo_count(fifo_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: expected port writes {rd, data}
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [EW-1:0] m_fifo[$];
  bit            m_pend[NR];
  bit            m_we;
  logic [RS-1:0] m_addr;
  bit            m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_haz(input logic [RS-1:0] q);
    return (q != 0) && (m_pend[q] || (m_we && m_addr == q));
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_stall = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid     = 1'b0;
    alu_rd        = '0;
    alu_data      = '0;
    lsu_valid     = 1'b0;
    lsu_rd        = '0;
    lsu_data      = '0;
    load_issue    = 1'b0;
    load_issue_rd = '0;
  endtask

  // driver: called at a negedge with inputs applied; checks combinational/registered
  // status against the model, advances the model by one cycle, then returns at the next negedge
  task automatic tick();
    bit            mready;
    logic [EW-1:0] e;
    #1;
    mready = (m_fifo.size() < FD);
    check("lsu_ready", lsu_ready, mready);
    check("fifo_count", fifo_count, m_fifo.size());
    check("hazard_1", hazard_1, m_haz(query_rs1));
    check("hazard_2", hazard_2, m_haz(query_rs2));
    if (alu_valid && alu_rd != 0) begin
      exp_q.push_back({alu_rd, alu_data});
      m_we   = 1'b1;
      m_addr = alu_rd;
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      exp_q.push_back(e);
      m_pend[e[EW-1:OS]] = 1'b0;
      m_we   = 1'b1;
      m_addr = e[EW-1:OS];
    end else begin
      m_we = 1'b0;
    end
    if (lsu_valid && mready && lsu_rd != 0) m_fifo.push_back({lsu_rd, lsu_data});
    if (load_issue && load_issue_rd != 0) m_pend[load_issue_rd] = 1'b1;
    m_stall = lsu_valid && !mready;
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: pops one expected write per observed port write
  initial begin : monitor
    logic [EW-1:0] e;
    logic [EW-1:0] last;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last = '0;
      end else if (write_enable_3 === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", write_enable_3, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", addr_3, e[EW-1:OS]);
          check("write_data", write_data_3, e[OS-1:0]);
          last = e;
        end
      end else begin
        check("hold_addr", addr_3, last[EW-1:OS]);
        check("hold_data", write_data_3, last[OS-1:0]);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    idle_inputs();
    query_rs1 = '0;
    query_rs2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_we", write_enable_3, 1'b0);
    check("rst_addr", addr_3, 0);
    check("rst_data", write_data_3, 0);
    check("rst_count", fifo_count, 0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    rst = 1'b0;
    tick();

    // ALU write, then ALU write to x0 (ignored)
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
    tick();
    alu_rd = 5'd0; alu_data = 32'h11111111;
    tick();
    idle_inputs();
    tick();

    // load to x9: hazard window from issue+1 through the port-write cycle
    load_issue = 1'b1; load_issue_rd = 5'd9; query_rs1 = 5'd9;
    tick();
    load_issue = 1'b0;
    tick();
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h12345678;
    tick();
    lsu_valid = 1'b0;
    repeat (3) tick();

    // ALU starvation: FIFO fills, then drains in order
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'b1; alu_rd = RS'(i + 1); alu_data = $urandom;
      if (!m_stall) begin
        lsu_valid = 1'b1; lsu_rd = RS'(16 + i); lsu_data = $urandom;
      end
      tick();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!m_stall) lsu_valid = 1'b0;
      tick();
    end

    // pop of x4 in the same cycle as a new load issue to x4
    idle_inputs();
    query_rs1 = 5'd4; query_rs2 = 5'd4;
    load_issue = 1'b1; load_issue_rd = 5'd4;
    tick();
    load_issue = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = $urandom;
    tick();
    lsu_valid = 1'b0; load_issue = 1'b1; load_issue_rd = 5'd4;
    tick();
    load_issue = 1'b0;
    repeat (3) tick();
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = $urandom;
    tick();
    lsu_valid = 1'b0;
    repeat (3) tick();

    // full FIFO with simultaneous pop and offer, several wrap passes
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        alu_valid = 1'b1; alu_rd = RS'(1 + i); alu_data = $urandom;
        lsu_valid = 1'b1; lsu_rd = RS'(20 + i + p); lsu_data = $urandom;
        tick();
      end
      alu_valid = 1'b0;
      lsu_rd = RS'(28 + p); lsu_data = $urandom;
      tick();
      for (int i = 0; i < 7; i++) begin
        if (!m_stall) lsu_valid = 1'b0;
        tick();
      end
    end

    // reset in the middle of traffic: 3 queued loads and x5 pending
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = $urandom;
    load_issue = 1'b1; load_issue_rd = 5'd5;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = $urandom;
    query_rs1 = 5'd5;
    tick();
    load_issue = 1'b0;
    lsu_rd = 5'd12; lsu_data = $urandom;
    tick();
    lsu_rd = 5'd13; lsu_data = $urandom;
    tick();
    lsu_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_we", write_enable_3, 1'b0);
    check("midrst_count", fifo_count, 0);
    check("midrst_hazard_1", hazard_1, 1'b0);
    check("midrst_lsu_ready", lsu_ready, 1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    check("midrst_lsu_ready_held", lsu_ready, 1'b0);
    rst = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd    = RS'($urandom_range(0, 31));
      alu_data  = $urandom;
      if (!m_stall) begin
        lsu_valid = ($urandom_range(0, 9) < 5);
        lsu_rd    = RS'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      load_issue    = ($urandom_range(0, 9) < 3);
      load_issue_rd = RS'($urandom_range(0, 31));
      query_rs1     = RS'($urandom_range(0, 31));
      query_rs2     = ($urandom_range(0, 1) == 1) ? m_addr : RS'($urandom_range(0, 31));
      tick();
    end

    // drain and final report
    alu_valid = 1'b0; load_issue = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!m_stall) lsu_valid = 1'b0;
      tick();
    end
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
